// File: rtl/sd_spi_master.sv
// Byte-wide SPI mode-0 master for SD cards: selectable slow/fast SCK, MSB-first,
// with a chip-select register whose writes are deferred while a byte is in flight.
module sd_spi_master #(
  parameter int DIV_SLOW = 70,
  parameter int DIV_FAST = 2
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       fast,
  input  logic       cs_wr,
  input  logic       cs_val,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic       sck,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  localparam logic [7:0] H_SLOW = 8'(DIV_SLOW);
  localparam logic [7:0] H_FAST = 8'(DIV_FAST);

  state_t     state_reg, state_next;
  logic [7:0] half_reg;
  logic [7:0] cnt_reg;
  logic [2:0] bit_reg;
  logic [7:0] tx_reg;
  logic [7:0] rx_sh_reg;
  logic [7:0] rx_data_reg;
  logic       sck_reg;
  logic       mosi_reg;
  logic       done_reg;
  logic       cs_n_reg;
  logic       pend_reg;
  logic       pend_val_reg;

  logic accept;
  logic phase_end;

  // The completion cycle is already IDLE, but a start there must wait one cycle.
  assign accept    = (state_reg == IDLE) && start && !done_reg;
  assign phase_end = (cnt_reg == half_reg - 8'd1);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = LOW;
      LOW:     if (phase_end) state_next = HIGH;
      HIGH:    if (phase_end) state_next = (bit_reg == 3'd7) ? IDLE : LOW;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg    <= IDLE;
      half_reg     <= H_SLOW;
      cnt_reg      <= 8'd0;
      bit_reg      <= 3'd0;
      tx_reg       <= 8'd0;
      rx_sh_reg    <= 8'd0;
      rx_data_reg  <= 8'hFF;
      sck_reg      <= 1'b0;
      mosi_reg     <= 1'b1;
      done_reg     <= 1'b0;
      cs_n_reg     <= 1'b1;
      pend_reg     <= 1'b0;
      pend_val_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      done_reg  <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (accept) begin
            tx_reg   <= tx_data;
            half_reg <= fast ? H_FAST : H_SLOW;
            mosi_reg <= tx_data[7];
            sck_reg  <= 1'b0;
            bit_reg  <= 3'd0;
            cnt_reg  <= 8'd0;
          end
        end
        LOW: begin
          if (phase_end) begin
            sck_reg   <= 1'b1;
            rx_sh_reg <= {rx_sh_reg[6:0], miso};
            cnt_reg   <= 8'd0;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        HIGH: begin
          if (phase_end) begin
            sck_reg <= 1'b0;
            cnt_reg <= 8'd0;
            if (bit_reg == 3'd7) begin
              done_reg    <= 1'b1;
              rx_data_reg <= rx_sh_reg;
              mosi_reg    <= 1'b1;
            end else begin
              bit_reg  <= bit_reg + 3'd1;
              tx_reg   <= {tx_reg[6:0], 1'b0};
              mosi_reg <= tx_reg[6];
            end
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        default: ;
      endcase

      // Chip select never moves mid-byte; a write during a transfer is parked
      // and lands in the cycle after done (a fresh write still wins over it).
      if (cs_wr) begin
        if (state_reg == IDLE) begin
          cs_n_reg <= cs_val;
          pend_reg <= 1'b0;
        end else begin
          pend_reg     <= 1'b1;
          pend_val_reg <= cs_val;
        end
      end else if (pend_reg && state_reg == IDLE) begin
        cs_n_reg <= pend_val_reg;
        pend_reg <= 1'b0;
      end
    end
  end

  assign rx_data = rx_data_reg;
  assign busy    = (state_reg != IDLE);
  assign done    = done_reg;
  assign sck     = sck_reg;
  assign mosi    = mosi_reg;
  assign cs_n    = cs_n_reg;

endmodule
